// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
// Shared constants and types for the framebuffer write side.
//   FB_W / FB_H / FB_PIXELS : 640x480 framebuffer geometry
//   ADDR_W / COLOR_W        : pixel address and color widths
//   CLEAR_CYCLES_DEF        : default cycles needed to clear one buffer
//   sched_state_t           : write-scheduler FSM states
//   ST_*                    : plain logic [2:0] state codes
// ---------------------------------------------------------------------------
package fb_pkg;

    localparam int FB_W             = 640;
    localparam int FB_H             = 480;
    localparam int FB_PIXELS        = FB_W * FB_H;
    localparam int ADDR_W           = 19;
    localparam int COLOR_W          = 4;
    localparam int CLEAR_CYCLES_DEF = FB_PIXELS + 2;

    typedef enum logic [2:0] {
        DRAW     = 3'd0,
        DRAIN    = 3'd1,
        WAIT_CLR = 3'd2,
        WAIT_VB  = 3'd3,
        SWAP     = 3'd4
    } sched_state_t;

    // Plain vector copies of the state codes, for use where an enum type
    // is inconvenient (register declarations, debug ports).
    localparam logic [2:0] ST_DRAW     = DRAW;
    localparam logic [2:0] ST_DRAIN    = DRAIN;
    localparam logic [2:0] ST_WAIT_CLR = WAIT_CLR;
    localparam logic [2:0] ST_WAIT_VB  = WAIT_VB;
    localparam logic [2:0] ST_SWAP     = SWAP;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Scans requesters starting at i_rr_ptr
// and grants the first one found; o_next_ptr is the slot after the winner,
// to be registered by the caller only when a grant is taken.
//   i_req      [NUM_REQ]  request vector
//   i_rr_ptr   [PTR_W]    first requester to consider this cycle
//   i_enable   1          when low no grant is issued
//   o_gnt      [NUM_REQ]  one-hot grant (all zero when none)
//   o_next_ptr [PTR_W]    pointer to use after this grant
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_rr_ptr,
    input  logic               i_enable,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [PTR_W-1:0]   o_next_ptr
);

    logic w_found;
    int   w_idx;
    int   w_nxt;

    always_comb begin
        o_gnt      = '0;
        o_next_ptr = i_rr_ptr;
        w_found    = 1'b0;
        w_idx      = 0;
        w_nxt      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // rr_ptr + k never exceeds 2*NUM_REQ-2, so one subtraction wraps it.
            w_idx = int'(i_rr_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (i_enable && !w_found && i_req[w_idx]) begin
                w_found      = 1'b1;
                o_gnt[w_idx] = 1'b1;
                w_nxt        = (w_idx + 1 == NUM_REQ) ? 0 : w_idx + 1;
                o_next_ptr   = PTR_W'(w_nxt);
            end
        end
    end

endmodule

// File: rtl/fb_write_sched.sv
// ---------------------------------------------------------------------------
// fb_write_sched
// Shares the single framebuffer write port between NUM_REQ pixel writers
// and sequences the triple-buffer swap strobe.
//   clk, rst      system clock, synchronous active-high reset
//   req           per-requester write valid
//   req_addr      packed 19-bit addresses, requester i at [19*i +: 19]
//   req_color     packed 4-bit colors, requester i at [4*i +: 4]
//   gnt           one-hot accept, combinational in the request cycle
//   frame_end     pulse: requesters have finished the current frame
//   vblank        vertical-blank level from the VGA timing
//   w_addr        framebuffer write address
//   color_out     framebuffer write color
//   en_w          framebuffer write enable
//   done          one-cycle swap strobe
//   frame_busy    writes blocked while a swap is pending
//   oob_err       sticky: an accepted address was >= FB_PIXELS
//   frame_cnt     number of completed swaps (wraps)
//   o_dbg_state   current scheduler state code (fb_pkg::ST_*)
//
// Handshake: a requester holds req[i] with its addr/color stable until it
// sees gnt[i] high in the same cycle; req[i] & gnt[i] is the transfer and
// the requester may present its next pixel in the following cycle.
// ---------------------------------------------------------------------------
module fb_write_sched #(
    parameter int NUM_REQ      = 2,
    parameter int FB_PIXELS    = 307200,
    parameter int CLEAR_CYCLES = 307202
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ*fb_pkg::ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*fb_pkg::COLOR_W-1:0]  req_color,
    output logic [NUM_REQ-1:0]                  gnt,
    input  logic                                frame_end,
    input  logic                                vblank,
    output logic [fb_pkg::ADDR_W-1:0]           w_addr,
    output logic [fb_pkg::COLOR_W-1:0]          color_out,
    output logic                                en_w,
    output logic                                done,
    output logic                                frame_busy,
    output logic                                oob_err,
    output logic [7:0]                          frame_cnt,
    output logic [2:0]                          o_dbg_state
);

    import fb_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);
    localparam logic [CLR_W-1:0] CLR_MAX = CLR_W'(CLEAR_CYCLES);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [2:0]         r_state;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [CLR_W-1:0]   r_clr_cnt;
    logic               r_vblank;
    logic               r_vb_armed;
    logic               r_en_w;
    logic [ADDR_W-1:0]  r_w_addr;
    logic [COLOR_W-1:0] r_color;
    logic               r_done;
    logic               r_oob;
    logic [7:0]         r_frame_cnt;

    // -----------------------------------------------------------------------
    // Wires
    // -----------------------------------------------------------------------
    logic [2:0]         w_next_state;
    logic [NUM_REQ-1:0] w_gnt;
    logic [PTR_W-1:0]   w_next_ptr;
    logic               w_any_gnt;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [COLOR_W-1:0] w_sel_color;
    logic               w_in_range;
    logic               w_vb_rise;
    logic               w_draw;

    assign w_draw    = (r_state == ST_DRAW);
    assign w_vb_rise = vblank & ~r_vblank;

    // -----------------------------------------------------------------------
    // Arbitration: grants only while drawing
    // -----------------------------------------------------------------------
    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .i_req      (req),
        .i_rr_ptr   (r_rr_ptr),
        .i_enable   (w_draw),
        .o_gnt      (w_gnt),
        .o_next_ptr (w_next_ptr)
    );

    assign w_any_gnt = |w_gnt;

    always_comb begin
        w_sel_addr  = '0;
        w_sel_color = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_color = req_color[i*COLOR_W +: COLOR_W];
            end
        end
    end

    assign w_in_range = (32'(w_sel_addr) < 32'(FB_PIXELS));

    // -----------------------------------------------------------------------
    // Scheduler FSM
    // -----------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_DRAW: begin
                if (frame_end) begin
                    w_next_state = ST_DRAIN;
                end
            end
            // One cycle for the last registered write to reach the port.
            ST_DRAIN: begin
                w_next_state = ST_WAIT_CLR;
            end
            ST_WAIT_CLR: begin
                if (r_clr_cnt == CLR_MAX) begin
                    w_next_state = ST_WAIT_VB;
                end
            end
            // r_vb_armed is low in the entry cycle, so a vblank that is
            // already high when we arrive is ignored until its next rise.
            ST_WAIT_VB: begin
                if (r_vb_armed && w_vb_rise) begin
                    w_next_state = ST_SWAP;
                end
            end
            ST_SWAP: begin
                w_next_state = ST_DRAW;
            end
            default: begin
                w_next_state = ST_DRAW;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_DRAW;
            r_done      <= 1'b0;
            r_frame_cnt <= 8'd0;
            r_vblank    <= 1'b0;
            r_vb_armed  <= 1'b0;
            r_clr_cnt   <= '0;
        end else begin
            r_state    <= w_next_state;
            // Registered so done is a clean flop output, high only in SWAP.
            r_done     <= (w_next_state == ST_SWAP);
            r_vblank   <= vblank;
            r_vb_armed <= (r_state == ST_WAIT_VB);
            if (r_state == ST_SWAP) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            // Counts from the last swap (or reset) and saturates; the buffer
            // just released by a swap is being cleared while this counts.
            if (r_state == ST_SWAP) begin
                r_clr_cnt <= '0;
            end else if (r_clr_cnt != CLR_MAX) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Arbiter pointer and registered write port
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_en_w   <= 1'b0;
            r_w_addr <= '0;
            r_color  <= '0;
            r_oob    <= 1'b0;
        end else begin
            if (w_any_gnt) begin
                r_rr_ptr <= w_next_ptr;
            end
            // Out-of-range pixels are consumed but never reach the port.
            r_en_w <= w_any_gnt & w_in_range;
            if (w_any_gnt && w_in_range) begin
                r_w_addr <= w_sel_addr;
                r_color  <= w_sel_color;
            end
            if (w_any_gnt && !w_in_range) begin
                r_oob <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign gnt         = w_gnt;
    assign w_addr      = r_w_addr;
    assign color_out   = r_color;
    assign en_w        = r_en_w;
    assign done        = r_done;
    assign frame_busy  = ~w_draw;
    assign oob_err     = r_oob;
    assign frame_cnt   = r_frame_cnt;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fb_write_sched.sv
// ---------------------------------------------------------------------------
// tb_fb_write_sched
// Directed bench for fb_write_sched with a shortened clear interval
// (CLEAR_CYCLES = 20) so whole frames fit in a short run.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_fb_write_sched;

    import fb_pkg::*;

    localparam int NREQ  = 2;
    localparam int NPIX  = 307200;
    localparam int CLR_C = 20;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0;
    logic [37:0] req_addr = '0;
    logic [7:0]  req_color = '0;
    logic [1:0]  gnt;
    logic        frame_end = 1'b0;
    logic        vblank = 1'b0;
    logic [18:0] w_addr;
    logic [3:0]  color_out;
    logic        en_w;
    logic        done;
    logic        frame_busy;
    logic        oob_err;
    logic [7:0]  frame_cnt;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    fb_write_sched #(
        .NUM_REQ      (NREQ),
        .FB_PIXELS    (NPIX),
        .CLEAR_CYCLES (CLR_C)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_addr    (req_addr),
        .req_color   (req_color),
        .gnt         (gnt),
        .frame_end   (frame_end),
        .vblank      (vblank),
        .w_addr      (w_addr),
        .color_out   (color_out),
        .en_w        (en_w),
        .done        (done),
        .frame_busy  (frame_busy),
        .oob_err     (oob_err),
        .frame_cnt   (frame_cnt),
        .o_dbg_state (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = '0;
        frame_end = 1'b0;
        vblank    = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic chk_sched(input string tag, input int c, input logic [2:0] est,
                             input logic edone, input logic ebusy, input logic [7:0] ecnt);
        chk($sformatf("%s c%0d state", tag, c), 32'(dbg_state), 32'(est));
        chk($sformatf("%s c%0d done", tag, c), 32'(done), 32'(edone));
        chk($sformatf("%s c%0d busy", tag, c), 32'(frame_busy), 32'(ebusy));
        chk($sformatf("%s c%0d frame_cnt", tag, c), 32'(frame_cnt), 32'(ecnt));
        if (ebusy) begin
            chk($sformatf("%s c%0d gnt idle", tag, c), 32'(gnt), 32'd0);
        end else begin
            chk($sformatf("%s c%0d gnt onehot", tag, c), 32'($onehot(gnt)), 32'd1);
        end
    endtask

    // ---------------- write scoreboard ----------------
    logic [22:0] exp_q[$];
    logic        sb_on = 1'b0;

    always @(negedge clk) begin
        if (sb_on && en_w) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_write: got %0h with no write expected", {w_addr, color_out});
            end else begin
                chk("sb_write", 32'({w_addr, color_out}), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  req;
        logic [18:0] a0;
        logic [18:0] a1;
        logic [3:0]  c0;
        logic [3:0]  c1;
        logic [1:0]  e_gnt;
        logic        e_en;
        logic [18:0] e_addr;
        logic [3:0]  e_color;
        logic        e_oob;
    } vec_t;

    vec_t vecs[17];

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main test ----------------
    initial begin
        logic [2:0]  est;
        logic [18:0] ga;
        logic [3:0]  gc;

        // Outputs in cycle k: gnt for this cycle's inputs, write port for
        // the grant of cycle k-1.
        vecs[0]  = '{2'b11, 19'd10,     19'd20,     4'h1, 4'h2, 2'b01, 1'b0, 19'd0,      4'h0, 1'b0};
        vecs[1]  = '{2'b11, 19'd10,     19'd20,     4'h1, 4'h2, 2'b10, 1'b1, 19'd10,     4'h1, 1'b0};
        vecs[2]  = '{2'b11, 19'd10,     19'd20,     4'h1, 4'h2, 2'b01, 1'b1, 19'd20,     4'h2, 1'b0};
        vecs[3]  = '{2'b11, 19'd10,     19'd20,     4'h1, 4'h2, 2'b10, 1'b1, 19'd10,     4'h1, 1'b0};
        vecs[4]  = '{2'b00, 19'd0,      19'd0,      4'h0, 4'h0, 2'b00, 1'b1, 19'd20,     4'h2, 1'b0};
        vecs[5]  = '{2'b01, 19'd1000,   19'd0,      4'hA, 4'h0, 2'b01, 1'b0, 19'd20,     4'h2, 1'b0};
        vecs[6]  = '{2'b00, 19'd0,      19'd0,      4'h0, 4'h0, 2'b00, 1'b1, 19'd1000,   4'hA, 1'b0};
        vecs[7]  = '{2'b00, 19'd0,      19'd0,      4'h0, 4'h0, 2'b00, 1'b0, 19'd1000,   4'hA, 1'b0};
        vecs[8]  = '{2'b10, 19'd0,      19'd555,    4'h0, 4'h3, 2'b10, 1'b0, 19'd1000,   4'hA, 1'b0};
        vecs[9]  = '{2'b10, 19'd0,      19'd556,    4'h0, 4'h4, 2'b10, 1'b1, 19'd555,    4'h3, 1'b0};
        vecs[10] = '{2'b01, 19'd7,      19'd0,      4'h5, 4'h0, 2'b01, 1'b1, 19'd556,    4'h4, 1'b0};
        vecs[11] = '{2'b11, 19'd8,      19'd9,      4'h6, 4'h7, 2'b10, 1'b1, 19'd7,      4'h5, 1'b0};
        vecs[12] = '{2'b00, 19'd0,      19'd0,      4'h0, 4'h0, 2'b00, 1'b1, 19'd9,      4'h7, 1'b0};
        vecs[13] = '{2'b01, 19'd307200, 19'd0,      4'hF, 4'h0, 2'b01, 1'b0, 19'd9,      4'h7, 1'b0};
        vecs[14] = '{2'b10, 19'd0,      19'd307199, 4'h0, 4'hE, 2'b10, 1'b0, 19'd9,      4'h7, 1'b1};
        vecs[15] = '{2'b00, 19'd0,      19'd0,      4'h0, 4'h0, 2'b00, 1'b1, 19'd307199, 4'hE, 1'b1};
        vecs[16] = '{2'b00, 19'd0,      19'd0,      4'h0, 4'h0, 2'b00, 1'b0, 19'd307199, 4'hE, 1'b1};

        // ---- reset values ----
        do_reset();
        @(negedge clk);
        chk("rst gnt", 32'(gnt), 32'd0);
        chk("rst en_w", 32'(en_w), 32'd0);
        chk("rst w_addr", 32'(w_addr), 32'd0);
        chk("rst color", 32'(color_out), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst busy", 32'(frame_busy), 32'd0);
        chk("rst oob", 32'(oob_err), 32'd0);
        chk("rst frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst state", 32'(dbg_state), 32'(ST_DRAW));
        next_cycle();

        // ---- table: arbitration, write latency, hold, out-of-bounds ----
        sb_on = 1'b1;
        for (int k = 0; k < 17; k++) begin
            req       = vecs[k].req;
            req_addr  = {vecs[k].a1, vecs[k].a0};
            req_color = {vecs[k].c1, vecs[k].c0};
            if (vecs[k].e_gnt != 2'b00) begin
                ga = vecs[k].e_gnt[0] ? vecs[k].a0 : vecs[k].a1;
                gc = vecs[k].e_gnt[0] ? vecs[k].c0 : vecs[k].c1;
                if (32'(ga) < 32'(NPIX)) exp_q.push_back({ga, gc});
            end
            @(negedge clk);
            chk($sformatf("vec%0d gnt", k), 32'(gnt), 32'(vecs[k].e_gnt));
            chk($sformatf("vec%0d en_w", k), 32'(en_w), 32'(vecs[k].e_en));
            chk($sformatf("vec%0d w_addr", k), 32'(w_addr), 32'(vecs[k].e_addr));
            chk($sformatf("vec%0d color", k), 32'(color_out), 32'(vecs[k].e_color));
            chk($sformatf("vec%0d oob", k), 32'(oob_err), 32'(vecs[k].e_oob));
            chk($sformatf("vec%0d busy", k), 32'(frame_busy), 32'd0);
            next_cycle();
        end
        sb_on = 1'b0;
        chk("sb queue empty", 32'(exp_q.size()), 32'd0);

        // ---- oob_err is sticky until reset ----
        req = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("oob sticky %0d", k), 32'(oob_err), 32'd1);
            next_cycle();
        end

        // ---- frame 1: clear wait, early vblank ignored, swap on rise ----
        do_reset();
        req_addr  = {19'd40, 19'd30};
        req_color = {4'h4, 4'h3};
        for (int c = 0; c <= 40; c++) begin
            req       = 2'b11;
            frame_end = (c == 3) || (c == 10) || (c == 27);
            vblank    = ((c >= 8) && (c <= 11)) || (c >= 26);
            @(negedge clk);
            if (c <= 3)       est = ST_DRAW;
            else if (c == 4)  est = ST_DRAIN;
            else if (c <= 20) est = ST_WAIT_CLR;
            else if (c <= 26) est = ST_WAIT_VB;
            else if (c == 27) est = ST_SWAP;
            else              est = ST_DRAW;
            chk_sched("f1", c, est, c == 27, (c >= 4) && (c <= 27), (c >= 28) ? 8'd1 : 8'd0);
            if (c == 0) chk("f1 oob cleared", 32'(oob_err), 32'd0);
            if (c == 4) chk("f1 drain write", 32'(en_w), 32'd1);
            if (c == 5) chk("f1 no write after drain", 32'(en_w), 32'd0);
            next_cycle();
        end

        // ---- frame 2: vblank already high on entry to WAIT_VB ----
        for (int c = 0; c <= 30; c++) begin
            req       = 2'b11;
            frame_end = (c == 0);
            vblank    = ((c >= 5) && (c <= 20)) || (c >= 23);
            @(negedge clk);
            if (c == 0)       est = ST_DRAW;
            else if (c == 1)  est = ST_DRAIN;
            else if (c <= 7)  est = ST_WAIT_CLR;
            else if (c <= 23) est = ST_WAIT_VB;
            else if (c == 24) est = ST_SWAP;
            else              est = ST_DRAW;
            chk_sched("f2", c, est, c == 24, (c >= 1) && (c <= 24), (c >= 25) ? 8'd2 : 8'd1);
            next_cycle();
        end

        // ---- frame 3: reset while in WAIT_VB ----
        vblank = 1'b0;
        for (int c = 0; c <= 18; c++) begin
            req       = 2'b00;
            frame_end = (c == 0);
            rst       = (c == 18);
            @(negedge clk);
            if (c == 0)       est = ST_DRAW;
            else if (c == 1)  est = ST_DRAIN;
            else if (c <= 14) est = ST_WAIT_CLR;
            else              est = ST_WAIT_VB;
            chk($sformatf("f3 c%0d state", c), 32'(dbg_state), 32'(est));
            chk($sformatf("f3 c%0d done", c), 32'(done), 32'd0);
            next_cycle();
        end
        rst = 1'b0;

        // After reset the full clear interval must elapse again.
        for (int c = 0; c <= 24; c++) begin
            frame_end = (c == 0);
            @(negedge clk);
            if (c == 0) begin
                chk("f4 post-rst busy", 32'(frame_busy), 32'd0);
                chk("f4 post-rst done", 32'(done), 32'd0);
                chk("f4 post-rst frame_cnt", 32'(frame_cnt), 32'd0);
                chk("f4 post-rst en_w", 32'(en_w), 32'd0);
            end
            if (c == 0)       est = ST_DRAW;
            else if (c == 1)  est = ST_DRAIN;
            else if (c <= 20) est = ST_WAIT_CLR;
            else              est = ST_WAIT_VB;
            chk($sformatf("f4 c%0d state", c), 32'(dbg_state), 32'(est));
            next_cycle();
        end
        frame_end = 1'b0;

        // ---- reset discards a write granted in the same cycle ----
        rst = 1'b1;
        next_cycle();
        rst       = 1'b0;
        next_cycle();
        req       = 2'b01;
        req_addr  = {19'd0, 19'd123};
        req_color = {4'h0, 4'h9};
        rst       = 1'b1;
        next_cycle();
        rst = 1'b0;
        req = 2'b00;
        @(negedge clk);
        chk("rst discard en_w", 32'(en_w), 32'd0);
        chk("rst discard w_addr", 32'(w_addr), 32'd0);
        chk("rst discard color", 32'(color_out), 32'd0);
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
